// File: rtl/bus_arb_pkg.sv
// Shared types and default sizes for the two-requester bus load arbiter.
package bus_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  typedef logic req_idx_t;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_CNT_W = 8;

endpackage

// File: rtl/bus_rr_pick.sv
// Combinational winner selection between two requesters, alternating on contention.
module bus_rr_pick
  import bus_arb_pkg::*;
(
  input  logic [1:0] valid,
  input  req_idx_t   last_grant,
  input  logic       en,
  output req_idx_t   winner,
  output logic       any
);

  always_comb begin
    any    = en & (|valid);
    winner = 1'b0;
    // On contention the requester that did not win last time goes next.
    if (valid == 2'b11) begin
      winner = ~last_grant;
    end else if (valid[1]) begin
      winner = 1'b1;
    end
  end

endmodule

// File: rtl/bus_load_arbiter.sv
// Two-requester arbiter feeding a single-entry output register with a transfer counter.
// Handshake: a side transfers on the cycle where its valid and ready are both high.
module bus_load_arbiter
  import bus_arb_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [1:0]       req_valid,
  input  logic [WIDTH-1:0] req_data0,
  input  logic [WIDTH-1:0] req_data1,
  output logic [1:0]       req_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output req_idx_t         grant_id,
  output logic [CNT_W-1:0] xfer_count,
  output state_t           dbg_state
);

  state_t   state, state_next;
  req_idx_t last_grant;
  req_idx_t winner;
  logic     any;
  logic     accept;
  logic     release_out;

  // Offers are only made from an empty register and never while reset is held.
  bus_rr_pick u_pick (
    .valid      (req_valid),
    .last_grant (last_grant),
    .en         (enable & rst_n & (state == IDLE)),
    .winner     (winner),
    .any        (any)
  );

  always_comb begin
    req_ready = 2'b00;
    if (any) begin
      req_ready[winner] = 1'b1;
    end
  end

  assign accept      = |(req_valid & req_ready);
  assign out_valid   = (state == HOLD);
  assign release_out = out_valid & out_ready;
  assign dbg_state   = state;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = HOLD;
      HOLD:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data   <= '0;
      grant_id   <= 1'b0;
      last_grant <= 1'b1;
      xfer_count <= '0;
    end else begin
      if (accept) begin
        out_data   <= winner ? req_data1 : req_data0;
        grant_id   <= winner;
        last_grant <= winner;
      end
      if (release_out) begin
        xfer_count <= xfer_count + CNT_W'(1);
      end
    end
  end

endmodule
